// File: rtl/servo_pkg.sv
// Shared servo timing constants for a 50 MHz system clock.
// Defaults give a 20 ms frame with 0.5..2.5 ms pulses centred at 1.5 ms.
package servo_pkg;

  localparam int CLK_HZ         = 50_000_000;
  localparam int PERIOD_DEF     = 1_000_000;
  localparam int DUTY_MIN_DEF   = 25_000;
  localparam int DUTY_MAX_DEF   = 125_000;
  localparam int DUTY_INIT_DEF  = 75_000;
  localparam int STEP_DEF       = 2_500;

  function automatic int us_to_cycles(input int us);
    return us * (CLK_HZ / 1_000_000);
  endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: clamped target, slew-limited current duty updated at the
// frame boundary, and the registered PWM compare against the shared counter.
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int CW        = 20,
  parameter int DUTY_MIN  = DUTY_MIN_DEF,
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int DUTY_INIT = DUTY_INIT_DEF,
  parameter int STEP      = STEP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic          wrap,
  input  logic [CW-1:0] duty,
  input  logic          load,
  input  logic          en,
  output logic          pwm,
  output logic          differs
);

  localparam logic [CW-1:0] DMIN  = CW'(DUTY_MIN);
  localparam logic [CW-1:0] DMAX  = CW'(DUTY_MAX);
  localparam logic [CW-1:0] DINIT = CW'(DUTY_INIT);
  // STEP saturated at 2^CW so the "close enough" compare never truncates.
  localparam logic [CW:0]   STEP_W = (longint'(STEP) >= (longint'(1) << CW)) ?
                                     {1'b1, {CW{1'b0}}} : (CW+1)'(STEP);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);

  logic [CW-1:0] tgt;
  logic [CW-1:0] cur;
  logic [CW-1:0] clamped;
  logic [CW-1:0] diff;
  logic [CW-1:0] nxt;
  logic          up;

  always_comb begin
    clamped = duty;
    if (duty < DMIN) clamped = DMIN;
    else if (duty > DMAX) clamped = DMAX;

    up   = (tgt > cur);
    diff = up ? (tgt - cur) : (cur - tgt);
    // The step is only added when diff > STEP, so cur+STEP stays below tgt.
    nxt  = tgt;
    if ({1'b0, diff} > STEP_W) nxt = up ? (cur + STEP_C) : (cur - STEP_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt <= DINIT;
      cur <= DINIT;
      pwm <= 1'b0;
    end else begin
      if (load) tgt <= clamped;
      if (wrap) cur <= nxt;
      pwm <= en && (cnt < cur);
    end
  end

  assign differs = (cur != tgt);

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of slew-limited servo PWM channels sharing one frame counter.
// frame_start marks the counter-zero cycle; busy reports any channel still slewing.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CH        = 4,
  parameter int CW        = 20,
  parameter int PERIOD    = PERIOD_DEF,
  parameter int DUTY_MIN  = DUTY_MIN_DEF,
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int DUTY_INIT = DUTY_INIT_DEF,
  parameter int STEP      = STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH*CW-1:0] duty_in,
  input  logic             load,
  input  logic [CH-1:0]    en,
  output logic [CH-1:0]    pwm_wave,
  output logic             frame_start,
  output logic             busy
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          wrap;
  logic [CH-1:0] differs;

  assign wrap        = (cnt == LAST);
  assign frame_start = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    servo_slew_ch #(
      .CW        (CW),
      .DUTY_MIN  (DUTY_MIN),
      .DUTY_MAX  (DUTY_MAX),
      .DUTY_INIT (DUTY_INIT),
      .STEP      (STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .wrap    (wrap),
      .duty    (duty_in[i*CW +: CW]),
      .load    (load),
      .en      (en[i]),
      .pwm     (pwm_wave[i]),
      .differs (differs[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= |differs;
  end

endmodule
